// File: rtl/r2r_wave_player_if.sv
// Write port for the wave player pattern memory: one 8-bit sample per accepted valid/ready beat.
interface r2r_wave_player_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/r2r_wave_player.sv
// Replays a stored pattern of 8-bit codes into the R2R DAC at a programmable rate.
// Latency: first sample 1 cycle after start; writes backpressured while playing or full.
module r2r_wave_player #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter int         DIV_W     = 8,
    parameter logic [7:0] IDLE_CODE = 8'h80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    r2r_wave_player_if.slave     wr,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [DIV_W-1:0]     div,
    output logic [7:0]           dac_code,
    output logic                 sample_stb,
    output logic                 busy,
    output logic [AW:0]          len
);
    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [AW:0]        len_q, len_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [7:0]         dac_code_q, dac_code_d;
    logic               sample_stb_q, sample_stb_d;
    logic [7:0]         mem_q [DEPTH];

    logic wr_fire;
    logic mem_we;
    logic last_sample;

    assign wr.wr_ready = (state_q == IDLE) && (len_q < DEPTH_L);
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign mem_we      = rst_n && wr_fire && !clear;
    // rd_ptr points one past the sample on the DAC; len==DEPTH aliases to 0 in AW bits.
    assign last_sample = (rd_ptr_q == len_q[AW-1:0]);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        dac_code_d   = dac_code_q;
        sample_stb_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    len_d = '0;
                end else if (wr_fire) begin
                    len_d = len_q + (AW+1)'(1);
                end
                // A clear in the same cycle empties the pattern, so it also suppresses start.
                if (start && !stop && !clear && (len_q != '0)) begin
                    state_d      = PLAY;
                    div_d        = div;
                    rd_ptr_d     = AW'(1);
                    cnt_d        = '0;
                    dac_code_d   = mem_q[0];
                    sample_stb_d = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    dac_code_d = IDLE_CODE;
                end else if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (!last_sample) begin
                        dac_code_d   = mem_q[rd_ptr_q];
                        rd_ptr_d     = rd_ptr_q + AW'(1);
                        sample_stb_d = 1'b1;
                    end else if (loop_en) begin
                        dac_code_d   = mem_q[0];
                        rd_ptr_d     = AW'(1);
                        sample_stb_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        dac_code_d = IDLE_CODE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            div_q        <= '0;
            dac_code_q   <= IDLE_CODE;
            sample_stb_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            dac_code_q   <= dac_code_d;
            sample_stb_q <= sample_stb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= wr.wr_data;
        end
    end

    assign dac_code   = dac_code_q;
    assign sample_stb = sample_stb_q;
    assign busy       = (state_q == PLAY);
    assign len        = len_q;
endmodule
